// File: rtl/nibble_seq_cmp.sv
// rtl/nibble_seq_cmp.sv - nibble-serial magnitude compare sequencer around a 4-bit comparator
//
// Purpose:
//    Accepts an operand pair over a valid/ready handshake, walks the operands one
//    nibble at a time from the MSB nibble down, feeds each nibble pair to an external
//    4-bit combinational comparator, and stops at the first unequal nibble.
//    One registered result is returned over a valid/ready handshake.
//
// Configuration macro:
//    NIBBLE_SEQ_CMP_SIGNED_EN - when defined, operands are two's complement. Bit 3 of
//    both MSB nibbles is inverted on the way to the comparator. When undefined, the
//    compare is unsigned and no inversion logic exists.
//
// Ports:
//    clk, rst_n            clock, asynchronous active-low reset
//    in_valid/in_ready     operand handshake; in_a/in_b are the WIDTH-bit operands
//    nib_a/nib_b           nibble pair driven to the comparator (valid in SCAN)
//    cmp_eq/cmp_gt/cmp_lt  comparator flags for the current nibble pair
//    out_valid/out_ready   result handshake
//    res_eq/res_gt/res_lt  final relation of A to B
//    res_cycles            number of SCAN cycles used (1..NIB)
//    res_err               comparator flags were not one-hot in the deciding cycle
module nibble_seq_cmp #(
   parameter  int WIDTH = 16,
   localparam int NIB   = WIDTH / 4,
   localparam int CW    = $clog2(NIB + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [3:0]       nib_a,
   output logic [3:0]       nib_b,
   input  logic             cmp_eq,
   input  logic             cmp_gt,
   input  logic             cmp_lt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             res_eq,
   output logic             res_gt,
   output logic             res_lt,
   output logic [CW-1:0]    res_cycles,
   output logic             res_err
);

   localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IW-1:0] IDX_MSB = IW'(NIB - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;

   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [IW-1:0]     idx_q;
   logic [CW-1:0]     count_q;

   logic [3:0]        nib_a_raw;
   logic [3:0]        nib_b_raw;

   logic              accept;
   logic              flags_onehot;
   logic              scan_done;
   logic              scan_step;

   // Nibble select straight from registered operands and index, so the
   // nib -> comparator -> flags path settles within the SCAN cycle. Because
   // a_q/b_q/idx_q only change on accept or while stepping, the nibbles
   // naturally hold their last values outside SCAN.
   assign nib_a_raw = a_q[{idx_q, 2'b00} +: 4];
   assign nib_b_raw = b_q[{idx_q, 2'b00} +: 4];

`ifdef NIBBLE_SEQ_CMP_SIGNED_EN
   // Marks that the MSB nibble is being presented. Kept as its own register
   // (rather than decoding idx_q in SCAN) so the inverted nibble is held
   // unchanged after SCAN exits from the first cycle.
   logic first_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_q <= 1'b0;
      end else if (accept) begin
         first_q <= 1'b1;
      end else if (scan_step) begin
         first_q <= 1'b0;
      end
   end

   // Flipping the sign bit maps two's complement order onto unsigned order.
   assign nib_a = nib_a_raw ^ {first_q, 3'b000};
   assign nib_b = nib_b_raw ^ {first_q, 3'b000};
`else
   assign nib_a = nib_a_raw;
   assign nib_b = nib_b_raw;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      accept       = 1'b0;
      scan_done    = 1'b0;
      scan_step    = 1'b0;
      flags_onehot = ({cmp_eq, cmp_gt, cmp_lt} == 3'b100) ||
                     ({cmp_eq, cmp_gt, cmp_lt} == 3'b010) ||
                     ({cmp_eq, cmp_gt, cmp_lt} == 3'b001);
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept  = 1'b1;
               state_d = SCAN;
            end
         end
         SCAN: begin
            // Any non-equal or malformed flag set ends the scan, as does an
            // equal LSB nibble; otherwise step to the next lower nibble.
            if (!flags_onehot || cmp_gt || cmp_lt || (idx_q == '0)) begin
               scan_done = 1'b1;
               state_d   = DONE;
            end else begin
               scan_step = 1'b1;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q        <= '0;
         b_q        <= '0;
         idx_q      <= '0;
         count_q    <= '0;
         res_eq     <= 1'b0;
         res_gt     <= 1'b0;
         res_lt     <= 1'b0;
         res_err    <= 1'b0;
         res_cycles <= '0;
      end else begin
         if (accept) begin
            a_q     <= in_a;
            b_q     <= in_b;
            idx_q   <= IDX_MSB;
            count_q <= '0;
         end
         if (state_q == SCAN) begin
            count_q <= count_q + CW'(1);
         end
         if (scan_step) begin
            idx_q <= idx_q - IW'(1);
         end
         if (scan_done) begin
            // A malformed flag set suppresses every relation output.
            res_err    <= !flags_onehot;
            res_eq     <= flags_onehot && cmp_eq;
            res_gt     <= flags_onehot && cmp_gt;
            res_lt     <= flags_onehot && cmp_lt;
            res_cycles <= count_q + CW'(1);
         end
      end
   end

endmodule

// File: doc/nibble_seq_cmp.md
Name: nibble_seq_cmp

Overview:
- Sequencer wrapped around the existing 4-bit combinational `comparator`.
- Compares two WIDTH-bit operands one nibble at a time, MSB nibble first.
- Drives nibble operands into `comparator` and consumes its EQ/GT/LT flags; stops at the first unequal nibble.
- Takes operands over a valid/ready input handshake; returns one registered result over a valid/ready output handshake.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, number of nibbles (derived; do not override).
- CW, clog2(NIB+1), width of the cycle-count output.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- nib_a  out  4  nibble to comparator input a
- nib_b  out  4  nibble to comparator input b
- cmp_eq  in  1  comparator A_eq_B
- cmp_gt  in  1  comparator A_gt_B
- cmp_lt  in  1  comparator A_lt_B
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- res_eq  out  1  A == B
- res_gt  out  1  A > B
- res_lt  out  1  A < B
- res_cycles  out  CW  SCAN cycles used, 1..NIB
- res_err  out  1  illegal flag combination seen

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0.
  - res_eq/res_gt/res_lt/res_err=0, res_cycles=0, nib_a=nib_b=0, internal operand registers=0.
- IDLE:
  - in_ready=1.
  - in_valid&in_ready: latch in_a/in_b into a_q/b_q, set idx=NIB-1, count=0, go SCAN.
  - in_ready drops the next cycle.
- SCAN:
  - nib_a = a_q[4*idx+3:4*idx] and nib_b likewise, driven combinationally from registered a_q/b_q/idx. The path nib -> comparator -> cmp_* therefore settles within the same cycle.
  - The flags are sampled each SCAN clock edge; count increments each SCAN cycle:
    - Flags not exactly one-hot: res_err=1, res_eq/gt/lt=0, go DONE.
    - cmp_gt: res_gt=1, go DONE.
    - cmp_lt: res_lt=1, go DONE.
    - cmp_eq and idx==0: res_eq=1, go DONE.
    - cmp_eq and idx>0: idx decrements, stay SCAN.
  - On leaving SCAN, res_cycles = count including the deciding cycle.
- DONE:
  - out_valid=1. res_* are stable and held until out_valid&out_ready.
  - On that handshake: out_valid=0, go IDLE, in_ready=1 the next cycle.
- Latency from input accept to out_valid:
  - 1 cycle into SCAN plus k SCAN cycles, where k is the index of the first differing nibble counted from the MSB (1..NIB).
  - Worst case NIB+1 cycles for equal operands.
- No input acceptance in SCAN/DONE; throughput is one comparison per result handshake. Back-to-back operation is not supported; the minimum cycle is accept, k SCAN, DONE, IDLE.
- Exactly one of res_eq/res_gt/res_lt is 1 while out_valid=1 and res_err=0.
- nib_a/nib_b hold their last values outside SCAN; downstream ignores them there.
- Reset asserted mid-SCAN or mid-DONE: everything returns to reset values immediately and the pending result is discarded.
- WIDTH=4: single SCAN cycle, res_cycles always 1.

Optional Feature:
- Macro: NIBBLE_SEQ_CMP_SIGNED_EN.
- Defined: operands are two's complement. In the first SCAN cycle (idx==NIB-1) bit 3 of both nib_a and nib_b is inverted before driving `comparator`, which turns a signed compare into an unsigned one. Lower nibbles are unchanged.
- Undefined: unsigned compare with no inversion logic present.

Test Plan:
- Unsigned, WIDTH=16: a=0x1234, b=0x1234 -> SCAN 4 cycles; res_eq=1, res_cycles=4, out_valid 5 cycles after accept.
- a=0x9000, b=0x8FFF -> res_gt=1, res_cycles=1; a=0x1233, b=0x1234 -> res_lt=1, res_cycles=4.
- Backpressure: a=0x00F0, b=0x00E0, out_ready held 0 for 6 cycles -> res_gt=1 and res_cycles=3 held stable, in_ready=0 throughout; release -> in_ready=1 the cycle after the handshake.
- Fault injection: force cmp_eq=cmp_gt=1 during SCAN -> res_err=1, res_eq/gt/lt=0, out_valid=1.
- Reset mid-SCAN (rst_n low for 1 cycle during a 0xFFFF vs 0xFFFE compare) -> out_valid=0, in_ready=1, no result emitted; the next compare 0x0001 vs 0x0002 gives res_lt=1.
- With NIBBLE_SEQ_CMP_SIGNED_EN: a=0xFFFF(-1), b=0x0001 -> res_lt=1, res_cycles=1. Without the macro, the same stimulus gives res_gt=1.
